write_ptr_full: RTL and testbench
=================================

# write_ptr_full

Write-domain pointer and status block of the dual-clock asynchronous FIFO. It owns the write pointer and produces the memory write address and the Gray-coded pointer sent to the read domain. It consumes the two-flop-synchronized read pointer and produces registered full, almost-full, fill-level and sticky-overflow status, all in the wclk domain.

## Interface
- ADDRESS_SIZE, 4: memory address width; FIFO depth = 2**ADDRESS_SIZE; legal range 2..16.
- ALMOST_FULL_THRESH, 2**ADDRESS_SIZE-2: wlevel at or above which walmost_full asserts; legal range 1..2**ADDRESS_SIZE.
- wclk  in  1  write clock.
- wrst_n  in  1  reset, asynchronous, active-low; clock wclk.
- winc  in  1  write request; accepted only when wfull is low.
- wovf_clr  in  1  clears woverflow.
- wq2_read_ptr  in  ADDRESS_SIZE+1  Gray read pointer, already synchronized into wclk.
- waddr  out  ADDRESS_SIZE  binary memory write address.
- wen  out  1  memory write enable, combinational = winc & ~wfull.
- write_ptr  out  ADDRESS_SIZE+1  registered Gray write pointer, to the read-domain synchronizer.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered, wlevel >= ALMOST_FULL_THRESH.
- wlevel  out  ADDRESS_SIZE+1  registered occupancy seen from the write side, 0..2**ADDRESS_SIZE.
- woverflow  out  1  sticky: a write was attempted while full.

## Operation
- State: wbin (binary, ADDRESS_SIZE+1 bits) and write_ptr (Gray), both registered.
- Accept: wen = winc & ~wfull. wbin_next = wbin + wen, modulo 2**(ADDRESS_SIZE+1). wgray_next = wbin_next ^ (wbin_next >> 1).
- waddr = wbin[ADDRESS_SIZE-1:0]. The memory writes at waddr on the same edge that advances the pointer.
- Full: wfull <= (wgray_next == {~wq2_read_ptr[MSB:MSB-1], wq2_read_ptr[MSB-2:0]}).
- Level: rbin_sync = gray2bin(wq2_read_ptr). wlevel <= (wbin_next - rbin_sync) mod 2**(ADDRESS_SIZE+1).
- Almost-full: walmost_full <= (wbin_next - rbin_sync) >= ALMOST_FULL_THRESH, computed from the same value as wlevel.
- Invariant: wfull == (wlevel == 2**ADDRESS_SIZE).
- wlevel and the flags update every cycle, including cycles with no write, because wq2_read_ptr can change.
- Overflow: if winc & wfull, woverflow <= 1. Otherwise, if wovf_clr, woverflow <= 0. A new overflow in the same cycle as wovf_clr wins, so woverflow stays 1.
- A blocked write changes no pointer, address or memory content.
- Wrap-around: binary 2**(ADDRESS_SIZE+1)-1 -> 0; Gray 1000..0 -> 0000..0. Exactly one bit of write_ptr changes per accepted write.
- The full flag is pessimistic. Reads are seen 2 wclk or more late, so full deasserts late and never asserts late. No write is ever lost or corrupted by this delay.

## Timing
- Reset (async assert, sync release by the system): wbin=0, write_ptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. wen=0 while winc is low.
- An accepted write on edge N gives:
  - write_ptr, waddr, wlevel and flags updated after edge N (1-cycle latency);
  - wfull asserted after edge N if that write fills the FIFO, so the next write is already blocked;
  - woverflow high after the edge where winc & wfull is sampled.
- A read-pointer change on wq2_read_ptr is reflected in wfull/wlevel after the next wclk edge.
- Reset mid-operation: all state returns to reset values immediately. The read side must be reset in the same reset event.

## Structure
- Shared package fifo_pkg holds:
  - function bin2gray;
  - function gray2bin (XOR prefix, parameterized width);
  - typedefs for the pointer width derived from ADDRESS_SIZE.
- One sub-module is natural: gray_to_bin, combinational, instanced for rbin_sync. The read-side empty logic reuses it.
- No memory inside this block. wen and waddr drive the dual-port RAM.

## Test plan
All scenarios use ADDRESS_SIZE=4 and ALMOST_FULL_THRESH=14.
- Fill: wq2_read_ptr=0, 16 consecutive winc.
  - walmost_full rises after the 14th write.
  - wfull rises after the 16th write; write_ptr=5'b11000, wlevel=16.
- Overflow: while full, assert winc for 1 cycle.
  - waddr/write_ptr unchanged, wen=0, woverflow=1.
  - Pulse wovf_clr -> woverflow=0. Assert winc and wovf_clr together while full -> woverflow stays 1.
- Drain visibility: from full, set wq2_read_ptr=5'b00001.
  - Next edge: wfull=0, wlevel=15.
  - One write then re-fills: wfull=1, write_ptr=gray(17)=5'b11001.
- Wrap: cycle the read pointer along so writes never block, for 40 writes.
  - write_ptr goes 5'b10000 -> 5'b00000 at the 32nd write; waddr wraps 15 -> 0 every 16 writes.
  - The checker confirms a single-bit Gray change per write.
- Reset mid-operation: assert wrst_n low after 7 writes with winc still high.
  - All outputs 0 immediately.
  - After release, the first write uses waddr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fifo_pkg                                                       |
// | Shared pointer types and Gray/binary helpers for the async FIFO.         |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
package fifo_pkg;

  localparam int PTR_MAX_W            = 17;
  localparam int DEFAULT_ADDRESS_SIZE = 4;

  typedef logic [PTR_MAX_W-1:0]          ptr_max_t;
  typedef logic [DEFAULT_ADDRESS_SIZE:0] ptr_t;

  // Callers zero-extend narrower pointers; the upper zeros leave low bits exact.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/write_ptr_full_gray_to_bin.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : write_ptr_full_gray_to_bin                                     |
// | Combinational Gray-to-binary converter (XOR prefix from the MSB down).   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module write_ptr_full_gray_to_bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/write_ptr_full.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : write_ptr_full                                                 |
// | Write-side pointer, Gray export and full/level/overflow status of the    |
// | dual-clock FIFO.                                                         |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module write_ptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE       = 4,
  parameter int ALMOST_FULL_THRESH = 2**ADDRESS_SIZE - 2
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic                    winc,
  input  logic                    wovf_clr,
  input  logic [ADDRESS_SIZE:0]   wq2_read_ptr,
  output logic [ADDRESS_SIZE-1:0] waddr,
  output logic                    wen,
  output logic [ADDRESS_SIZE:0]   write_ptr,
  output logic                    wfull,
  output logic                    walmost_full,
  output logic [ADDRESS_SIZE:0]   wlevel,
  output logic                    woverflow
);

  localparam int PTR_W = ADDRESS_SIZE + 1;

  logic [PTR_W-1:0] r_wbin;
  logic [PTR_W-1:0] r_wgray;
  logic             r_wfull;
  logic             r_walmost_full;
  logic [PTR_W-1:0] r_wlevel;
  logic             r_woverflow;

  logic             w_wen;
  logic [PTR_W-1:0] w_wbin_next;
  logic [PTR_W-1:0] w_wgray_next;
  logic [PTR_W-1:0] w_rbin_sync;
  logic [PTR_W-1:0] w_level_next;
  logic [PTR_W-1:0] w_full_match;
  logic             w_full_next;
  logic             w_almost_next;

  write_ptr_full_gray_to_bin #(
    .WIDTH (PTR_W)
  ) u_rptr_g2b (
    .i_gray (wq2_read_ptr),
    .o_bin  (w_rbin_sync)
  );

  assign w_wen        = winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + {{ADDRESS_SIZE{1'b0}}, w_wen};
  assign w_wgray_next = PTR_W'(bin2gray(ptr_max_t'(w_wbin_next)));

  // Full when the write pointer is a whole lap ahead: top two Gray bits inverted.
  assign w_full_match  = {~wq2_read_ptr[PTR_W-1:PTR_W-2], wq2_read_ptr[PTR_W-3:0]};
  assign w_full_next   = (w_wgray_next == w_full_match);
  assign w_level_next  = w_wbin_next - w_rbin_sync;
  assign w_almost_next = (w_level_next >= PTR_W'(ALMOST_FULL_THRESH));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wgray        <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wgray        <= w_wgray_next;
      r_wfull        <= w_full_next;
      r_walmost_full <= w_almost_next;
      r_wlevel       <= w_level_next;
      // A fresh overflow takes priority over a simultaneous clear.
      if (winc && r_wfull) begin
        r_woverflow <= 1'b1;
      end else if (wovf_clr) begin
        r_woverflow <= 1'b0;
      end
    end
  end

  assign wen          = w_wen;
  assign waddr        = r_wbin[ADDRESS_SIZE-1:0];
  assign write_ptr    = r_wgray;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_woverflow;

endmodule
`default_nettype wire

// File: tb/tb_write_ptr_full.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_write_ptr_full                                              |
// | Self-checking bench: occupancy-count model plus directed vectors.        |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module tb_write_ptr_full;
  import fifo_pkg::*;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic       wovf_clr = 1'b0;
  ptr_t       rcnt = '0;
  logic [4:0] wq2_read_ptr;
  logic [3:0] waddr;
  logic       wen;
  logic [4:0] write_ptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int checks   = 0;
  int failures = 0;

  assign wq2_read_ptr = rcnt ^ (rcnt >> 1);

  always #5 wclk = ~wclk;

  write_ptr_full #(
    .ADDRESS_SIZE       (4),
    .ALMOST_FULL_THRESH (14)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wovf_clr     (wovf_clr),
    .wq2_read_ptr (wq2_read_ptr),
    .waddr        (waddr),
    .wen          (wen),
    .write_ptr    (write_ptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count of accepted writes and occupancy, in plain integers.
  int m_wcnt  = 0;
  int m_level = 0;
  bit m_full  = 0;
  bit m_af    = 0;
  bit m_ovf   = 0;
  bit m_wrote = 0;

  function automatic int next_wcnt(input int cnt, input bit inc, input bit full);
    return (cnt + ((inc && !full) ? 1 : 0)) % 32;
  endfunction

  function automatic int occ(input int w, input int r);
    return (w - r + 64) % 32;
  endfunction

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_wcnt  <= 0;
      m_level <= 0;
      m_full  <= 0;
      m_af    <= 0;
      m_ovf   <= 0;
      m_wrote <= 0;
    end else begin
      m_wcnt  <= next_wcnt(m_wcnt, winc, m_full);
      m_level <= occ(next_wcnt(m_wcnt, winc, m_full), int'(rcnt));
      m_full  <= occ(next_wcnt(m_wcnt, winc, m_full), int'(rcnt)) == 16;
      m_af    <= occ(next_wcnt(m_wcnt, winc, m_full), int'(rcnt)) >= 14;
      m_wrote <= winc && !m_full;
      if (winc && m_full) m_ovf <= 1;
      else if (wovf_clr)  m_ovf <= 0;
    end
  end

  logic [4:0] dut_prev_ptr = '0;

  always @(negedge wclk) begin
    if (!wrst_n) begin
      dut_prev_ptr <= '0;
    end else begin
      check("m_waddr", waddr, m_wcnt % 16);
      check("m_write_ptr", write_ptr, gray(m_wcnt));
      check("m_wfull", wfull, m_full);
      check("m_walmost_full", walmost_full, m_af);
      check("m_wlevel", wlevel, m_level);
      check("m_woverflow", woverflow, m_ovf);
      check("m_wen", wen, winc && !m_full);
      check("m_gray_step", $countones(write_ptr ^ dut_prev_ptr), m_wrote ? 1 : 0);
      dut_prev_ptr <= write_ptr;
    end
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  int w;

  initial begin
    repeat (2) tick();
    check("rst_waddr", waddr, 0);
    check("rst_write_ptr", write_ptr, 0);
    check("rst_wfull", wfull, 0);
    check("rst_wlevel", wlevel, 0);
    check("rst_wen", wen, 0);
    wrst_n = 1'b1;
    tick();

    // Fill
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 13) check("fill_af13", walmost_full, 0);
      if (i == 14) check("fill_af14", walmost_full, 1);
      if (i == 15) check("fill_full15", wfull, 0);
    end
    check("fill_full16", wfull, 1);
    check("fill_ptr16", write_ptr, 5'b11000);
    check("fill_level16", wlevel, 16);
    check("fill_wen_blocked", wen, 0);

    // Overflow
    tick();
    check("ovf_set", woverflow, 1);
    check("ovf_ptr", write_ptr, 5'b11000);
    check("ovf_waddr", waddr, 0);
    winc = 1'b0; wovf_clr = 1'b1;
    tick();
    check("ovf_clr", woverflow, 0);
    winc = 1'b1;
    tick();
    check("ovf_wins", woverflow, 1);
    winc = 1'b0; wovf_clr = 1'b0;

    // Drain visibility
    rcnt = 5'd1;
    tick();
    check("drain_full", wfull, 0);
    check("drain_level", wlevel, 15);
    winc = 1'b1;
    tick();
    check("refill_full", wfull, 1);
    check("refill_ptr", write_ptr, 5'b11001);
    w = 17;

    // Wrap with reader trailing by four
    winc = 1'b0; wovf_clr = 1'b1; rcnt = 5'd13;
    tick();
    check("wrap_pre_ovf", woverflow, 0);
    wovf_clr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      rcnt = 5'(w - 4);
      winc = 1'b1;
      tick();
      w++;
      if (w % 32 == 31) check("wrap_ptr31", write_ptr, 5'b10000);
      if (w % 32 == 0)  check("wrap_ptr0", write_ptr, 5'b00000);
      if (w % 16 == 15) check("wrap_waddr15", waddr, 15);
      if (w % 16 == 0)  check("wrap_waddr0", waddr, 0);
    end

    // Reset mid-operation
    rcnt = 5'(w);
    for (int k = 0; k < 7; k++) tick();
    #1 wrst_n = 1'b0;
    #1;
    check("mrst_waddr", waddr, 0);
    check("mrst_write_ptr", write_ptr, 0);
    check("mrst_wfull", wfull, 0);
    check("mrst_af", walmost_full, 0);
    check("mrst_level", wlevel, 0);
    check("mrst_ovf", woverflow, 0);
    rcnt = '0;
    tick();
    wrst_n = 1'b1;
    check("post_rst_waddr", waddr, 0);
    check("post_rst_wen", wen, 1);
    tick();
    check("post_rst_waddr1", waddr, 1);
    check("post_rst_ptr1", write_ptr, 5'b00001);
    check("post_rst_level1", wlevel, 1);
    winc = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
